// File: rtl/uart_resp_pkg.sv
// uart_resp_pkg: shared constants and FSM state type for the UART register
// responder.
//   OP_WRITE / OP_READ : command opcodes that open a frame
//   ACK / NAK          : first response byte
//   state_e            : responder FSM states
// Optional feature macro: UART_RESP_CHECKSUM_EN adds the GET_CHK state.
package uart_resp_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
`ifdef UART_RESP_CHECKSUM_EN
        S_GET_CHK,
`endif
        S_RESP0,
        S_RESP1
    } state_e;

endpackage

// File: rtl/uart_resp_regfile.sv
// uart_resp_regfile: 2**ADDR_WIDTH x DATA_WIDTH register array.
//   clk, rst_n       : clock, synchronous active-low reset (clears all entries)
//   we_i/waddr_i/wdata_i : synchronous write port
//   raddr_a_i/rdata_a_o  : combinational read port (internal)
//   raddr_b_i/rdata_b_o  : combinational read port (fabric)
// Reads return the pre-write value during the write cycle.
module uart_resp_regfile #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_b_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**ADDR_WIDTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/uart_reg_responder.sv
// uart_reg_responder: parses 'W'/'R' command frames from a UART byte stream,
// accesses a local register file and returns ACK(+data) or NAK bytes.
//   clk, rst_n                      : clock, synchronous active-low reset
//   rx_valid, rx_data, rx_parity_err: received byte strobe (no backpressure)
//   tx_valid, tx_data, tx_ready     : response byte handshake
//   wr_strobe, wr_addr              : one-cycle register-write notification
//   rd_addr, rd_data                : fabric combinational read port
//   frame_err                       : pulse on NAK, timeout or dropped byte
// Optional feature macro: UART_RESP_CHECKSUM_EN (trailing XOR CHK byte).
module uart_reg_responder
    import uart_resp_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 110_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_parity_err,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_ready,
    output logic                  wr_strobe,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  frame_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e                state_q;
    logic                  is_wr_q;
    logic                  two_q;      // read response: data byte follows ACK
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] rd_byte_q;
    logic [CW-1:0]         cnt_q;
    logic                  tx_valid_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  wr_strobe_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic                  frame_err_q;
`ifdef UART_RESP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] chk_q;
    logic [DATA_WIDTH-1:0] chk_d;
`endif

    logic                  in_get, byte_ok, chk_bad, exec_wr, exec_rd, nak_d;
    logic [ADDR_WIDTH-1:0] int_rd_addr;
    logic [DATA_WIDTH-1:0] int_rd_data, wr_data_d;

    // Frame decode: which byte completes the frame, and whether it fails.
    always_comb begin
        in_get  = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA);
        byte_ok = rx_valid && !rx_parity_err;
`ifdef UART_RESP_CHECKSUM_EN
        in_get      = in_get || (state_q == S_GET_CHK);
        chk_d       = chk_q ^ rx_data;
        chk_bad     = (state_q == S_GET_CHK) && (rx_data != chk_q);
        exec_wr     = byte_ok && (state_q == S_GET_CHK) && !chk_bad && is_wr_q;
        exec_rd     = byte_ok && (state_q == S_GET_CHK) && !chk_bad && !is_wr_q;
        int_rd_addr = addr_q;
        wr_data_d   = data_q;
`else
        // Without CHK the frame's last byte is still on rx_data at execute.
        chk_bad     = 1'b0;
        exec_wr     = byte_ok && (state_q == S_GET_DATA);
        exec_rd     = byte_ok && (state_q == S_GET_ADDR) && !is_wr_q;
        int_rd_addr = rx_data[ADDR_WIDTH-1:0];
        wr_data_d   = rx_data;
`endif
        nak_d = in_get && rx_valid && (rx_parity_err || chk_bad);
    end

    uart_resp_regfile #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (exec_wr),
        .waddr_i  (addr_q),
        .wdata_i  (wr_data_d),
        .raddr_a_i(int_rd_addr),
        .rdata_a_o(int_rd_data),
        .raddr_b_i(rd_addr),
        .rdata_b_o(rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            is_wr_q     <= 1'b0;
            two_q       <= 1'b0;
            addr_q      <= '0;
            rd_byte_q   <= '0;
            cnt_q       <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_RESP_CHECKSUM_EN
            data_q      <= '0;
            chk_q       <= '0;
`endif
        end else begin
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            cnt_q       <= '0;
            if (nak_d) begin
                tx_valid_q  <= 1'b1;
                tx_data_q   <= NAK;
                two_q       <= 1'b0;
                frame_err_q <= 1'b1;
                state_q     <= S_RESP0;
            end else if (exec_wr || exec_rd) begin
                tx_valid_q  <= 1'b1;
                tx_data_q   <= ACK;
                two_q       <= exec_rd;
                rd_byte_q   <= int_rd_data;
                wr_strobe_q <= exec_wr;
                if (exec_wr) wr_addr_q <= addr_q;
                state_q     <= S_RESP0;
            end else if (in_get && !rx_valid) begin
                // Inter-byte gap: abandon the frame silently once it expires.
                if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    frame_err_q <= 1'b1;
                    state_q     <= S_IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (byte_ok && (rx_data == OP_WRITE || rx_data == OP_READ)) begin
                            is_wr_q <= (rx_data == OP_WRITE);
`ifdef UART_RESP_CHECKSUM_EN
                            chk_q   <= rx_data;
`endif
                            state_q <= S_GET_ADDR;
                        end
                    end
                    S_GET_ADDR: begin
                        addr_q  <= rx_data[ADDR_WIDTH-1:0];
`ifdef UART_RESP_CHECKSUM_EN
                        chk_q   <= chk_d;
                        state_q <= is_wr_q ? S_GET_DATA : S_GET_CHK;
`else
                        state_q <= S_GET_DATA;
`endif
                    end
`ifdef UART_RESP_CHECKSUM_EN
                    S_GET_DATA: begin
                        data_q  <= rx_data;
                        chk_q   <= chk_d;
                        state_q <= S_GET_CHK;
                    end
`endif
                    S_RESP0: begin
                        if (rx_valid) frame_err_q <= 1'b1;
                        if (tx_ready) begin
                            if (two_q) begin
                                tx_data_q <= rd_byte_q;
                                state_q   <= S_RESP1;
                            end else begin
                                tx_valid_q <= 1'b0;
                                state_q    <= S_IDLE;
                            end
                        end
                    end
                    S_RESP1: begin
                        if (rx_valid) frame_err_q <= 1'b1;
                        if (tx_ready) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench for uart_reg_responder: stimulus pushes expected response
// bytes and write addresses; negedge monitors pop and compare.
module tb_uart_reg_responder;

    localparam int AW = 4;
    localparam int TO = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_parity_err = 1'b0;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready = 1'b1;
    logic          wr_strobe;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic          frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int fe_cnt = 0;
    int fe0;
    logic [7:0]    exp_tx[$];
    logic [AW-1:0] exp_wr[$];

    uart_reg_responder #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitors: response bytes on handshake, register writes on strobe.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL tx_unexpected: got byte %0h, expected none", tx_data);
            end else check("tx_byte", tx_data, exp_tx.pop_front());
        end
        if (rst_n && wr_strobe) begin
            if (exp_wr.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL wr_unexpected: got addr %0h, expected none", wr_addr);
            end else check("wr_addr", wr_addr, exp_wr.pop_front());
        end
        if (frame_err) fe_cnt++;
    end

    task automatic present(input logic [7:0] b, input logic perr);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = b; rx_parity_err = perr;
    endtask

    task automatic release_rx();
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_parity_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends a full frame, leaving its final byte presented (not yet accepted).
    task automatic frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                         input bit bad_chk);
        logic [7:0] chk;
        chk = op ^ a;
        present(op, 1'b0);
        present(a, 1'b0);
        if (op == 8'h57) begin
            present(d, 1'b0);
            chk = chk ^ d;
        end
        chk = bad_chk ? 8'h00 : chk;
`ifdef UART_RESP_CHECKSUM_EN
        present(chk, 1'b0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        rd_addr = 4'd3;
        idle(3);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_reg3", rd_data, 8'h00);
        rst_n = 1'b1;
        idle(2);

        // Write 0xA5 to reg 3
        exp_tx.push_back(8'h06);
        exp_wr.push_back(4'd3);
        frame(8'h57, 8'h03, 8'hA5, 1'b0);
        #2;
        check("wr_same_cycle_old", rd_data, 8'h00);
        release_rx();
        check("wr_strobe", wr_strobe, 1);
        check("wr_ack_valid", tx_valid, 1);
        check("wr_ack_data", tx_data, 8'h06);
        check("wr_reg3_new", rd_data, 8'hA5);
        idle(2);
        check("wr_done_idle", tx_valid, 0);

        // Read reg 3 with data byte held by tx_ready=0
        exp_tx.push_back(8'h06);
        exp_tx.push_back(8'hA5);
        frame(8'h52, 8'h03, 8'h00, 1'b0);
        release_rx();
        check("rd_ack_data", tx_data, 8'h06);
        idle(1);
        check("rd_data_valid", tx_valid, 1);
        check("rd_data_byte", tx_data, 8'hA5);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("rd_hold_valid", tx_valid, 1);
            check("rd_hold_data", tx_data, 8'hA5);
        end
        tx_ready = 1'b1;
        idle(1);
        check("rd_done_valid", tx_valid, 0);
        idle(1);

`ifdef UART_RESP_CHECKSUM_EN
        // Bad checksum -> NAK, no write
        fe0 = fe_cnt;
        rd_addr = 4'd5;
        exp_tx.push_back(8'h15);
        frame(8'h57, 8'h05, 8'h11, 1'b1);
        release_rx();
        check("chk_nak_data", tx_data, 8'h15);
        check("chk_frame_err", frame_err, 1);
        check("chk_no_strobe", wr_strobe, 0);
        idle(2);
        check("chk_fe_count", fe_cnt, fe0 + 1);
        check("chk_reg5", rd_data, 8'h00);
`endif

        // Parity error mid-frame -> NAK
        fe0 = fe_cnt;
        exp_tx.push_back(8'h15);
        present(8'h57, 1'b0);
        present(8'h05, 1'b1);
        release_rx();
        check("par_nak_data", tx_data, 8'h15);
        check("par_frame_err", frame_err, 1);
        idle(2);
        // Idle garbage and a parity-flagged opcode are dropped silently
        present(8'hFF, 1'b0);
        release_rx();
        present(8'h57, 1'b1);
        release_rx();
        idle(3);
        check("idle_garbage_fe", fe_cnt, fe0 + 1);
        check("idle_garbage_tx", tx_valid, 0);

        // Inter-byte timeout, then a good frame
        fe0 = fe_cnt;
        present(8'h57, 1'b0);
        present(8'h02, 1'b0);
        release_rx();
        idle(TO + 5);
        check("to_fe_count", fe_cnt, fe0 + 1);
        check("to_no_tx", tx_valid, 0);
        rd_addr = 4'd9;
        exp_tx.push_back(8'h06);
        exp_wr.push_back(4'd9);
        frame(8'h57, 8'h09, 8'hC3, 1'b0);
        release_rx();
        check("to_recover_reg9", rd_data, 8'hC3);
        idle(2);

        // Byte arriving during a stalled response is dropped
        rd_addr = 4'hA;
        exp_tx.push_back(8'h06);
        exp_wr.push_back(4'hA);
        tx_ready = 1'b0;
        frame(8'h57, 8'h0A, 8'h5A, 1'b0);
        release_rx();
        check("drop_tx_valid", tx_valid, 1);
        fe0 = fe_cnt;
        present(8'h33, 1'b0);
        release_rx();
        check("drop_frame_err", frame_err, 1);
        check("drop_tx_held", tx_data, 8'h06);
        tx_ready = 1'b1;
        idle(2);
        check("drop_fe_count", fe_cnt, fe0 + 1);
        check("drop_done", tx_valid, 0);
        check("drop_reg10", rd_data, 8'h5A);

        // Reset during a pending read response
        tx_ready = 1'b0;
        frame(8'h52, 8'h0A, 8'h00, 1'b0);
        release_rx();
        check("rstm_tx_valid", tx_valid, 1);
        check("rstm_tx_data", tx_data, 8'h06);
        rst_n = 1'b0;
        idle(1);
        check("rstm_tx_cleared", tx_valid, 0);
        for (int i = 0; i < 16; i++) begin
            rd_addr = AW'(i);
            #1;
            check("rstm_reg_zero", rd_data, 8'h00);
        end
        rst_n = 1'b1;
        tx_ready = 1'b1;
        idle(3);
        check("rstm_idle", tx_valid, 0);

        check("exp_tx_drained", exp_tx.size(), 0);
        check("exp_wr_drained", exp_wr.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
